// File: rtl/gemm_c_writeback.sv
// Output-drain stage: buffers row-major C results in a small FIFO and
// writes them to SRAM C at consecutive addresses, pulsing done_o at the end.
module gemm_c_writeback #(
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 12,
  parameter int SizeAddrWidth = 8,
  parameter int FifoDepth     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [SizeAddrWidth-1:0] M_size_i,
  input  logic [SizeAddrWidth-1:0] N_size_i,
  input  logic                     res_valid_i,
  input  logic [OutDataWidth-1:0]  res_data_i,
  output logic                     res_ready_o,
  output logic [AddrWidth-1:0]     sram_c_addr_o,
  output logic [OutDataWidth-1:0]  sram_c_wdata_o,
  output logic                     sram_c_we_o,
  input  logic                     sram_c_gnt_i,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int TotW = 2 * SizeAddrWidth;
  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = PtrW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [TotW-1:0]         total_q, total_d, total_new;
  logic [TotW-1:0]         in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic [AddrWidth-1:0]    addr_q, addr_d;
  logic [PtrW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [OutDataWidth-1:0] mem_q [FifoDepth];
  logic                    run, fifo_full, fifo_empty, push, pop;

  assign run        = (state_q == RUN);
  assign fifo_full  = (count_q == CntW'(FifoDepth));
  assign fifo_empty = (count_q == '0);
  assign total_new  = TotW'(M_size_i) * TotW'(N_size_i);

  // Ready never anticipates a same-cycle pop, keeping it a pure register function
  assign res_ready_o    = run && !fifo_full && (in_cnt_q < total_q);
  assign push           = res_valid_i && res_ready_o;
  assign sram_c_we_o    = run && !fifo_empty;
  assign pop            = sram_c_we_o && sram_c_gnt_i;
  assign sram_c_wdata_o = sram_c_we_o ? mem_q[rd_ptr_q] : '0;
  assign sram_c_addr_o  = addr_q;
  assign busy_o         = run;
  assign done_o         = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    addr_d    = addr_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          total_d   = total_new;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          addr_d    = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
          state_d   = (total_new == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push) begin
          in_cnt_d = in_cnt_q + TotW'(1);
          wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
          out_cnt_d = out_cnt_q + TotW'(1);
          addr_d    = addr_q + AddrWidth'(1);
          rd_ptr_d  = rd_ptr_q + PtrW'(1);
          if (out_cnt_d == total_q) state_d = DONE;
        end
        count_d = count_q + CntW'(push) - CntW'(pop);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      total_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      addr_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      addr_q    <= addr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  // Storage is data-only; occupancy tracking alone decides what is valid
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= res_data_i;
  end

endmodule

// File: doc/gemm_c_writeback.md
# gemm_c_writeback

Output-drain stage of the GEMM accelerator. It sits between the MAC datapath's result stream and the output memory C. It accepts finished C elements in row-major order through a valid/ready handshake and buffers them in a small FIFO. It then writes them into C's single write port at consecutive addresses (address = m*N + n), stalling on the memory grant. It signals `done_o` once all M*N elements have been committed.

## Interface
- OutDataWidth, 32, width of one C element
- AddrWidth, 12, SRAM C address width
- SizeAddrWidth, 8, width of the M/N size inputs
- FifoDepth, 4, result buffer entries (power of two, >= 2)

- clk_i  in  1  clock; all logic on rising edge
- rst_ni  in  1  synchronous, active-low reset
- start_i  in  1  begin a drain job; sampled only in IDLE
- M_size_i  in  SizeAddrWidth  rows of C; latched on accepted start
- N_size_i  in  SizeAddrWidth  columns of C; latched on accepted start
- res_valid_i  in  1  result element valid
- res_data_i  in  OutDataWidth  result element (signed, passed through unmodified)
- res_ready_o  out  1  block can accept an element this cycle
- sram_c_addr_o  out  AddrWidth  write address
- sram_c_wdata_o  out  OutDataWidth  write data (FIFO head)
- sram_c_we_o  out  1  write request
- sram_c_gnt_i  in  1  memory accepts the write this cycle
- busy_o  out  1  job in progress (state RUN)
- done_o  out  1  one-cycle pulse: all elements committed

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start_i`, latch `total = M_size_i*N_size_i` (2*SizeAddrWidth bits), then go to RUN.
  - Entering RUN clears `in_cnt`, `out_cnt`, the address counter and the FIFO.
  - If total == 0, go directly to DONE instead.
- RUN:
  - `res_ready_o = !fifo_full && (in_cnt < total)`.
  - Push occurs when `res_valid_i && res_ready_o`; it increments `in_cnt`.
  - Elements offered after `in_cnt == total` are not accepted; ready stays low.
  - `sram_c_we_o = !fifo_empty`; wdata = FIFO head; addr = address counter.
  - Commit occurs when `sram_c_we_o && sram_c_gnt_i`: pop the FIFO, increment `out_cnt` and the address.
  - Address wraps modulo 2^AddrWidth. Callers guarantee total <= 2^AddrWidth.
  - RUN -> DONE on the commit that makes `out_cnt == total`.
- DONE: `done_o = 1` for exactly one cycle, then go to IDLE.
- `start_i` is ignored in RUN and DONE. Sizes are not re-sampled mid-job.
- Simultaneous push and pop in the same cycle: occupancy is unchanged, and both take effect.
- `res_ready_o` does not look ahead to a same-cycle pop. When full, ready is low even if a pop occurs that cycle.
- Data is stored bit-exact; the block does no arithmetic on data.

## Timing
- Reset (`rst_ni == 0` at a clock edge):
  - state goes to IDLE, FIFO empties, all counters clear.
  - outputs: res_ready_o=0, sram_c_we_o=0, sram_c_addr_o=0, sram_c_wdata_o=0, busy_o=0, done_o=0.
- Reset mid-job aborts it immediately. No further writes are issued and `done_o` is not pulsed.
- A start accepted at edge T gives: busy_o=1 and res_ready_o=1 in cycle T+1.
- An element pushed at edge T is visible on `sram_c_we_o`/addr/wdata in cycle T+1, giving 1-cycle latency.
- With `sram_c_gnt_i` tied high and a continuous valid stream, throughput is 1 element/cycle and the FIFO never exceeds 1 entry.
- While `sram_c_gnt_i` is low, `sram_c_we_o`, addr and wdata are held stable until granted.
- `done_o` is asserted in the cycle after the final commit edge; IDLE is re-entered the cycle after that.
- Zero-size job: start at edge T gives `done_o` in cycle T+1 with no writes.
- Outside RUN, `res_ready_o`, `sram_c_we_o` and `busy_o` are 0.

## Test plan
- **Basic 4x4 job.** M=4, N=4, gnt tied 1, elements 0..15 streamed back-to-back:
  - 16 writes at addresses 0..15 with data 0..15, one per cycle.
  - `done_o` pulses once, one cycle after the write to addr 15.
- **Backpressure.** M=2, N=3, gnt held 0 for 10 cycles, valid held high with values 100..105:
  - `res_ready_o` drops after exactly 4 accepts; addr 0/wdata 100 is held stable.
  - After gnt rises, all 6 values are written in order to addr 0..5.
- **Bursty grant.** M=3, N=5, gnt toggling 1/0, valid random:
  - memory image equals the stream row-major.
  - there are 15 commits in total, with no duplicates or drops.
  - a 16th element offered after acceptance 15 is refused.
- **Zero size.** M=0, N=7:
  - `done_o` pulses in the cycle after start.
  - `sram_c_we_o` never rises and `res_ready_o` stays 0.
- **Reset mid-job.** M=4, N=4, assert `rst_ni=0` after 5 commits:
  - all outputs are 0 next cycle and `done_o` never pulses.
  - a fresh 2x2 job then writes addr 0..3 correctly.
- **Start while busy.** Pulse `start_i` with M=9 during a 4x4 job:
  - it is ignored; exactly 16 writes occur and one `done_o` pulse.
